// File: rtl/fsm_mon_pkg.sv
// Shared types for the sequencer monitor: phase codes, monitor states and the
// legal-advance helper used by the transition checker.
package fsm_mon_pkg;

    typedef enum logic [1:0] {
        S0     = 2'd0,
        S1     = 2'd1,
        S2     = 2'd2,
        PH_ILL = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2,
        FAULT = 2'd3
    } mon_state_t;

    // The only legal successor of each phase; S2 wraps back to S0.
    function automatic phase_t next_phase(input phase_t ph);
        case (ph)
            S0:      return S1;
            S1:      return S2;
            default: return S0;
        endcase
    endfunction

endpackage

// File: rtl/fsm_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear beats increment.
module fsm_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fsm_seq_monitor.sv
// Runtime checker for the 3-phase sequencer: flags illegal codes, illegal
// transitions and stalls, counts errors (saturating) and completed loops.
module fsm_seq_monitor
    import fsm_mon_pkg::*;
#(
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 16,
    parameter int ALLOW_HOLD = 0,
    parameter int STALL_MAX  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            phase_in,
    input  logic                  valid_in,
    input  logic                  clr_err,
    output logic                  illegal_code,
    output logic                  illegal_trans,
    output logic                  stall_err,
    output logic                  err_pulse,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [WRAP_CNT_W-1:0] wrap_cnt,
    output logic [1:0]            mon_state
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SYNC  = SYNC;
    localparam logic [1:0] ST_TRACK = TRACK;
    localparam logic [1:0] ST_FAULT = FAULT;

    localparam int              HOLD_W    = $clog2(STALL_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STALL_MAX - 1);

    logic [1:0]            state_q, state_d;
    phase_t                prev_q, prev_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic                  code_q, trans_q, stall_q, pulse_q;
    logic [WRAP_CNT_W-1:0] wrap_q;

    phase_t ph;
    logic   ev_code, ev_trans, ev_stall, wrap_inc, err_any, clr_eff;

    assign ph      = phase_t'(phase_in);
    assign clr_eff = valid_in & clr_err;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        hold_d   = hold_q;
        ev_code  = 1'b0;
        ev_trans = 1'b0;
        ev_stall = 1'b0;
        wrap_inc = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_SYNC;
            ST_SYNC: begin
                if (ph == S0) begin
                    state_d = ST_TRACK;
                    prev_d  = S0;
                    hold_d  = '0;
                end else if (ph == PH_ILL) begin
                    ev_code = 1'b1;
                    state_d = ST_FAULT;
                end
            end
            ST_TRACK: begin
                if (ph == PH_ILL) begin
                    ev_code = 1'b1;
                    state_d = ST_FAULT;
                end else if (ph == next_phase(prev_q)) begin
                    prev_d   = ph;
                    hold_d   = '0;
                    wrap_inc = (prev_q == S2);
                end else if ((ph == prev_q) && (ALLOW_HOLD != 0)) begin
                    if (hold_q == HOLD_LAST) begin
                        ev_stall = 1'b1;
                        state_d  = ST_FAULT;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else begin
                    ev_trans = 1'b1;
                    state_d  = ST_FAULT;
                end
            end
            default: ;
        endcase

        // Override order: dropping valid outranks a clear, which outranks any error.
        if (clr_eff || !valid_in) begin
            ev_code  = 1'b0;
            ev_trans = 1'b0;
            ev_stall = 1'b0;
            wrap_inc = 1'b0;
            state_d  = valid_in ? ST_SYNC : ST_IDLE;
        end
    end

    assign err_any = ev_code | ev_trans | ev_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prev_q  <= S0;
            hold_q  <= '0;
            code_q  <= 1'b0;
            trans_q <= 1'b0;
            stall_q <= 1'b0;
            pulse_q <= 1'b0;
            wrap_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            hold_q  <= hold_d;
            pulse_q <= err_any;
            if (clr_eff) begin
                code_q  <= 1'b0;
                trans_q <= 1'b0;
                stall_q <= 1'b0;
                wrap_q  <= '0;
            end else begin
                if (ev_code)  code_q  <= 1'b1;
                if (ev_trans) trans_q <= 1'b1;
                if (ev_stall) stall_q <= 1'b1;
                if (wrap_inc) wrap_q  <= wrap_q + WRAP_CNT_W'(1);
            end
        end
    end

    fsm_sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (err_any),
        .clr_i (clr_eff),
        .cnt_o (err_cnt)
    );

    assign illegal_code  = code_q;
    assign illegal_trans = trans_q;
    assign stall_err     = stall_q;
    assign err_pulse     = pulse_q;
    assign wrap_cnt      = wrap_q;
    assign mon_state     = state_q;

endmodule

// File: doc/fsm_seq_monitor.md
Name: fsm_seq_monitor

Overview:
Runtime checker placed directly downstream of the 3-phase sequencer (S0->S1->S2->S0). It consumes the sequencer's 2-bit state output every cycle and flags illegal codes, illegal transitions and stalls. Errors are kept as sticky flags with a saturating error count, and completed S0..S2 loops are counted. Outputs feed a status/debug register block.

Parameters:
ERR_CNT_W, 8, width of the saturating error counter.
WRAP_CNT_W, 16, width of the loop counter; wraps modulo 2^WRAP_CNT_W.
ALLOW_HOLD, 0, 1 = phase may repeat (hold) legally; 0 = any repeat is an illegal transition.
STALL_MAX, 8, number of consecutive repeated samples that triggers a stall; must be >= 1; used only when ALLOW_HOLD=1.

Ports:
clk  in  1  single clock; all logic on posedge
rst_n  in  1  synchronous, active-low reset
phase_in  in  2  sequencer state code: 0=S0, 1=S1, 2=S2, 3=illegal
valid_in  in  1  monitor enable; low forces IDLE
clr_err  in  1  clears sticky flags and counters; FAULT -> SYNC
illegal_code  out  1  sticky: phase_in==3 seen in SYNC/TRACK
illegal_trans  out  1  sticky: skip, backward step, or (ALLOW_HOLD=0) repeat
stall_err  out  1  sticky: hold limit reached
err_pulse  out  1  one-cycle pulse per counted error event
err_cnt  out  ERR_CNT_W  error events, saturating at all-ones
wrap_cnt  out  WRAP_CNT_W  count of S2->S0 transitions in TRACK
mon_state  out  2  IDLE=0, SYNC=1, TRACK=2, FAULT=3

Behaviour:
- Reset (rst_n low at posedge): all outputs 0; mon_state=IDLE; prev phase=S0; hold_cnt=0.
- Every output is registered. An event sampled at edge N is visible after edge N.
- IDLE:
  - valid_in=1 -> SYNC.
- SYNC (aligning):
  - phase_in==S0 -> TRACK, prev<=S0, hold_cnt<=0.
  - phase_in==3 -> illegal_code event, go to FAULT.
  - Otherwise stay in SYNC with no error.
- TRACK (compare phase_in against prev each cycle):
  - phase_in == (prev+1) mod 3: legal advance. prev<=phase_in, hold_cnt<=0. wrap_cnt+1 on S2->S0.
  - phase_in == prev with ALLOW_HOLD=1: legal hold, hold_cnt+1. When hold_cnt reaches STALL_MAX: stall_err event, go to FAULT.
  - phase_in == prev with ALLOW_HOLD=0: illegal_trans event, go to FAULT.
  - phase_in==3: illegal_code event, go to FAULT. Takes priority over all other checks.
  - Any other value: illegal_trans event, go to FAULT.
- FAULT:
  - No further checking and no counting.
  - clr_err=1 -> SYNC.
- Global precedence, highest first: rst_n, valid_in=0 (-> IDLE from any state; sticky flags and counters kept), clr_err, error detection.
- Error event:
  - Sets the matching sticky flag.
  - err_pulse=1 for exactly one cycle.
  - err_cnt+1, saturating at 2^ERR_CNT_W-1 (stays at max, no wrap).
  - At most one event per cycle.
- clr_err=1:
  - Zeroes all sticky flags, err_cnt and wrap_cnt on the same edge; forces err_pulse=0.
  - An error present in the same cycle is ignored (clear wins).
  - In TRACK or SYNC, clr_err goes to SYNC.
- wrap_cnt rolls from all-ones to 0.

Decomposition:
- Package fsm_mon_pkg:
  - phase_t enum (S0=0, S1=1, S2=2, PH_ILL=3).
  - mon_state_t enum (IDLE, SYNC, TRACK, FAULT).
  - Function next_phase(phase_t) implementing S2->S0 wrap.
- One sub-module, fsm_sat_counter: parameterised width, inc/clr inputs, saturates at max. Instantiated for err_cnt.

Test Plan:
1. Clean run: reset, valid_in=1, phase 0,1,2,0,1,2,0 -> mon_state=TRACK, no flags, err_cnt=0, wrap_cnt=2.
2. Illegal code: in TRACK after S1, drive 3 -> next cycle illegal_code=1, err_pulse=1 for one cycle, err_cnt=1, mon_state=FAULT. Then clr_err=1 -> flags and err_cnt 0, mon_state=SYNC.
3. Skip and backward (ALLOW_HOLD=0): S0->S2 -> illegal_trans=1, err_cnt=1. After clr, S0,S1,S0 -> illegal_trans=1 again. A repeat S1,S1 -> illegal_trans.
4. Hold, ALLOW_HOLD=1, STALL_MAX=4:
   - S1 then 3 repeats, then S2 -> no error.
   - S1 then 4 repeats -> stall_err=1, FAULT.
5. Saturation, ERR_CNT_W=2: provoke 5 faults with clr-free recovery via valid_in toggle -> err_cnt 1,2,3,3,3. err_pulse fires all 5 times.
6. Corner cases:
   - clr_err coincident with illegal code -> flags 0, err_cnt 0, no pulse.
   - rst_n low mid-TRACK -> all outputs 0, IDLE next cycle.
   - valid_in low in FAULT -> IDLE with flags retained.
